// File: rtl/adc_sample_avg_if.sv
// -----------------------------------------------------------------------------
// adc_sample_avg_if
// Bundles the sample input strobe, the clear control and the averaged-output
// handshake of adc_sample_avg.
//   sample_valid / sample_data : one-cycle strobe with a signed ADC reading
//   clear                      : synchronous flush of accumulator, FIFO, flag
//   out_ready                  : consumer accepts out_data when out_valid=1
//   out_valid / out_data       : FIFO head is present / signed averaged value
//   fifo_count                 : current FIFO occupancy
//   overflow                   : sticky "average dropped on full FIFO" flag
// master = the side feeding samples and consuming averages, slave = the block.
// DATA_WIDTH and FIFO_DEPTH must match the parameters of the attached block.
// -----------------------------------------------------------------------------
interface adc_sample_avg_if #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16
);
    logic                          sample_valid;
    logic [DATA_WIDTH-1:0]         sample_data;
    logic                          clear;
    logic                          out_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output sample_valid, sample_data, clear, out_ready,
        input  out_valid, out_data, fifo_count, overflow
    );

    modport slave (
        input  sample_valid, sample_data, clear, out_ready,
        output out_valid, out_data, fifo_count, overflow
    );
endinterface

// File: rtl/adc_sample_avg.sv
// -----------------------------------------------------------------------------
// adc_sample_avg
// Averages groups of 2^LOG2_AVG signed ADC samples (arithmetic shift, floor
// toward minus infinity) and queues the results in a first-word-fall-through
// FIFO of FIFO_DEPTH entries.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : adc_sample_avg_if.slave (sample strobe, clear, output handshake,
//          fifo_count, sticky overflow)
// Parameters:
//   DATA_WIDTH : sample width (two's complement)
//   LOG2_AVG   : log2 of the group size, 0..8
//   FIFO_DEPTH : power of two, >= 2
// -----------------------------------------------------------------------------
module adc_sample_avg #(
    parameter int DATA_WIDTH = 24,
    parameter int LOG2_AVG   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    adc_sample_avg_if.slave bus
);
    localparam int ACC_W = DATA_WIDTH + LOG2_AVG;
    // A zero-width counter is not legal; with LOG2_AVG=0 the single bit
    // simply stays at zero and every sample is the last of its group.
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {ST_ACCUM, ST_EMIT} state_t;

    // ------------------------------------------------------------------
    // Accumulator / group FSM
    // ------------------------------------------------------------------
    state_t                  state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0]   result_reg, result_next;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    push_req;

    // Size cast of a signed operand sign-extends; the accumulator is wide
    // enough for 2^LOG2_AVG full-scale samples so the sum never wraps.
    assign sample_ext = ACC_W'($signed(bus.sample_data));
    assign sum        = acc_reg + sample_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_ACCUM;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
        end
    end

    // EMIT lasts one cycle and only pushes result_reg. Sample handling is
    // identical in both states, so a strobe during EMIT starts the next
    // group (or, when it completes a group, immediately re-enters EMIT
    // with a new result while the old one is being pushed).
    always_comb begin
        state_next  = ST_ACCUM;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        push_req    = (state_reg == ST_EMIT);

        if (bus.sample_valid) begin
            if (cnt_reg == CNT_LAST) begin
                result_next = DATA_WIDTH'(sum >>> LOG2_AVG);
                acc_next    = '0;
                cnt_next    = '0;
                state_next  = ST_EMIT;
            end else begin
                acc_next = sum;
                cnt_next = cnt_reg + 1'b1;
            end
        end

        // clear wins over the strobe and over any pending push
        if (bus.clear) begin
            state_next  = ST_ACCUM;
            acc_next    = '0;
            cnt_next    = '0;
            result_next = result_reg;
            push_req    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]        count_reg;
    logic                  overflow_reg;
    logic                  empty, full, pop, push_ok, drop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FIFO_FULL);
    assign pop     = !empty && bus.out_ready && !bus.clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    // When full with a simultaneous pop, wr_ptr equals rd_ptr and the head
    // being popped is overwritten at the same edge it is consumed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= result_reg;
        end
    end

    assign bus.out_valid  = !empty;
    assign bus.out_data   = empty ? '0 : mem[rd_ptr_reg];
    assign bus.fifo_count = count_reg;
    assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_adc_sample_avg.sv
module tb_adc_sample_avg;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // three configurations: A (avg 4, depth 16), B (avg 2, depth 16), C (pass-through, depth 4)
    adc_sample_avg_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(16)) ifa ();
    adc_sample_avg_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(16)) ifb ();
    adc_sample_avg_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(4))  ifc ();

    adc_sample_avg #(.DATA_WIDTH(DW), .LOG2_AVG(2), .FIFO_DEPTH(16)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    adc_sample_avg #(.DATA_WIDTH(DW), .LOG2_AVG(1), .FIFO_DEPTH(16)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));
    adc_sample_avg #(.DATA_WIDTH(DW), .LOG2_AVG(0), .FIFO_DEPTH(4))  u_dut_c (.clk(clk), .rst(rst), .bus(ifc));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a pending group sum, a pending completed average,
    // and a queue standing in for the FIFO contents.
    // ------------------------------------------------------------------
    int     mq [3][$];
    longint msum [3];
    int     mn [3];
    bit     mpend [3];
    int     mval [3];
    bit     movf [3];

    function automatic int lg_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 0);
    endfunction

    function automatic int depth_of(input int i);
        return (i == 2) ? 4 : 16;
    endfunction

    task automatic model_step(input int i, input logic sv, input logic [DW-1:0] sd,
                              input logic clr, input logic rdy, input logic r);
        bit pop_m;
        bit push_m;
        if (r || clr) begin
            mq[i].delete();
            msum[i]  = 0;
            mn[i]    = 0;
            mpend[i] = 0;
            movf[i]  = 0;
            return;
        end
        pop_m  = (mq[i].size() > 0) && rdy;
        push_m = 0;
        if (mpend[i]) begin
            if (mq[i].size() < depth_of(i) || pop_m) push_m = 1;
            else movf[i] = 1;
        end
        if (pop_m) void'(mq[i].pop_front());
        if (push_m) mq[i].push_back(mval[i]);
        mpend[i] = 0;
        if (sv) begin
            msum[i] += longint'($signed(sd));
            mn[i]++;
            if (mn[i] == (1 << lg_of(i))) begin
                mval[i]  = int'(msum[i] >>> lg_of(i));
                mpend[i] = 1;
                msum[i]  = 0;
                mn[i]    = 0;
            end
        end
    endtask

    task automatic check_inst(input int i, input logic ov, input logic [DW-1:0] od,
                              input int fc, input logic ovf);
        string p;
        logic [DW-1:0] e;
        p = $sformatf("model_u%0d", i);
        chk({p, ".out_valid"}, longint'(ov), longint'(mq[i].size() != 0));
        chk({p, ".fifo_count"}, longint'(fc), longint'(mq[i].size()));
        chk({p, ".overflow"}, longint'(ovf), longint'(movf[i]));
        if (mq[i].size() != 0) begin
            e = DW'(mq[i][0]);
            chk({p, ".out_data"}, longint'(od), longint'(e));
        end else if (rst) begin
            chk({p, ".out_data_rst"}, longint'(od), 0);
        end
    endtask

    always @(posedge clk) begin
        model_step(0, ifa.sample_valid, ifa.sample_data, ifa.clear, ifa.out_ready, rst);
        model_step(1, ifb.sample_valid, ifb.sample_data, ifb.clear, ifb.out_ready, rst);
        model_step(2, ifc.sample_valid, ifc.sample_data, ifc.clear, ifc.out_ready, rst);
        #2;
        check_inst(0, ifa.out_valid, ifa.out_data, int'(ifa.fifo_count), ifa.overflow);
        check_inst(1, ifb.out_valid, ifb.out_data, int'(ifb.fifo_count), ifb.overflow);
        check_inst(2, ifc.out_valid, ifc.out_data, int'(ifc.fifo_count), ifc.overflow);
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    int got_q[$];

    task automatic set_idle();
        ifa.sample_valid = 0; ifa.sample_data = '0; ifa.clear = 0; ifa.out_ready = 0;
        ifb.sample_valid = 0; ifb.sample_data = '0; ifb.clear = 0; ifb.out_ready = 0;
        ifc.sample_valid = 0; ifc.sample_data = '0; ifc.clear = 0; ifc.out_ready = 0;
    endtask

    // four consecutive strobes on A, latency / value / count checks, then pop
    task automatic group_a(input string name, input int s0, input int s1,
                           input int s2, input int s3, input int expv);
        int s[4];
        logic [DW-1:0] e;
        s = '{s0, s1, s2, s3};
        e = DW'(expv);
        ifa.out_ready = 0;
        for (int j = 0; j < 4; j++) begin
            ifa.sample_valid = 1;
            ifa.sample_data  = DW'(s[j]);
            @(negedge clk);
        end
        ifa.sample_valid = 0;
        chk({name, ".valid_1cyc"}, longint'(ifa.out_valid), 0);
        @(negedge clk);
        chk({name, ".valid_2cyc"}, longint'(ifa.out_valid), 1);
        chk({name, ".data"}, longint'(ifa.out_data), longint'(e));
        chk({name, ".count"}, longint'(ifa.fifo_count), 1);
        ifa.out_ready = 1;
        @(negedge clk);
        ifa.out_ready = 0;
        chk({name, ".count_after_pop"}, longint'(ifa.fifo_count), 0);
    endtask

    task automatic pulse_clear_c();
        ifc.clear = 1;
        @(negedge clk);
        ifc.clear = 0;
    endtask

    task automatic drain_c(input int cycles);
        got_q.delete();
        ifc.out_ready = 1;
        for (int c = 0; c < cycles; c++) begin
            if (ifc.out_valid && ifc.out_ready) got_q.push_back(int'(ifc.out_data));
            @(negedge clk);
        end
        ifc.out_ready = 0;
    endtask

    typedef struct {
        string name;
        int s0, s1, s2, s3;
        int expv;
    } vec_t;

    vec_t tbl[7];
    int   exp_b[4];

    initial begin
        tbl[0] = '{"avg_basic",   10, 20, 30, 41, 25};
        tbl[1] = '{"floor_neg",   -1, -1, -1, -2, -2};
        tbl[2] = '{"pos_full",    8388607, 8388607, 8388607, 8388607, 8388607};
        tbl[3] = '{"neg_full",    -8388608, -8388608, -8388608, -8388608, -8388608};
        tbl[4] = '{"avg_small",   1, 2, 3, 4, 2};
        tbl[5] = '{"floor_quart", -1, 0, 0, 0, -1};
        tbl[6] = '{"mixed_sign",  100, -50, 7, -60, -1};
        exp_b  = '{1, 3, 5, 7};

        set_idle();
        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst.out_valid", longint'(ifa.out_valid), 0);
        chk("rst.fifo_count", longint'(ifa.fifo_count), 0);
        chk("rst.overflow", longint'(ifa.overflow), 0);
        chk("rst.out_data", longint'(ifa.out_data), 0);
        rst = 0;
        @(negedge clk);

        // --- table of averaging vectors on configuration A ---
        foreach (tbl[k]) begin
            group_a(tbl[k].name, tbl[k].s0, tbl[k].s1, tbl[k].s2, tbl[k].s3, tbl[k].expv);
        end

        // --- clear mid-group together with a strobe ---
        ifa.sample_valid = 1; ifa.sample_data = DW'(100); @(negedge clk);
        ifa.sample_data = DW'(200); @(negedge clk);
        ifa.clear = 1; ifa.sample_data = DW'(999); @(negedge clk);
        ifa.clear = 0; ifa.sample_valid = 0;
        chk("clear.out_valid", longint'(ifa.out_valid), 0);
        chk("clear.count", longint'(ifa.fifo_count), 0);
        group_a("after_clear", 4, 8, 12, 16, 10);

        // --- reset asserted while EMIT is pending ---
        for (int j = 0; j < 4; j++) begin
            ifa.sample_valid = 1; ifa.sample_data = DW'(50); @(negedge clk);
        end
        ifa.sample_valid = 0;
        rst = 1;
        @(negedge clk);
        chk("rst_emit.out_valid", longint'(ifa.out_valid), 0);
        chk("rst_emit.count", longint'(ifa.fifo_count), 0);
        chk("rst_emit.out_data", longint'(ifa.out_data), 0);
        rst = 0;
        @(negedge clk);
        group_a("after_rst", 1, 2, 3, 6, 3);

        // --- back-to-back strobes on B (pairs) ---
        got_q.delete();
        ifb.out_ready = 1;
        for (int c = 0; c < 30; c++) begin
            if (ifb.out_valid && ifb.out_ready) got_q.push_back(int'($signed(ifb.out_data)));
            if (c < 8) begin
                ifb.sample_valid = 1; ifb.sample_data = DW'(c + 1);
            end else begin
                ifb.sample_valid = 0;
            end
            @(negedge clk);
        end
        ifb.out_ready = 0;
        chk("b2b.n_out", got_q.size(), 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("b2b.out%0d", j), (j < got_q.size()) ? got_q[j] : -1, exp_b[j]);

        // --- full / overflow on C ---
        pulse_clear_c();
        for (int v = 11; v <= 15; v++) begin
            ifc.sample_valid = 1; ifc.sample_data = DW'(v); @(negedge clk);
        end
        ifc.sample_valid = 0;
        repeat (2) @(negedge clk);
        chk("full.count", longint'(ifc.fifo_count), 4);
        chk("full.overflow", longint'(ifc.overflow), 1);
        chk("full.head", longint'(ifc.out_data), 11);
        drain_c(10);
        chk("drain.n_out", got_q.size(), 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("drain.out%0d", j), (j < got_q.size()) ? got_q[j] : -1, 11 + j);
        chk("drain.overflow_sticky", longint'(ifc.overflow), 1);
        chk("drain.count", longint'(ifc.fifo_count), 0);
        pulse_clear_c();
        chk("clear.overflow", longint'(ifc.overflow), 0);

        // --- simultaneous push and pop at full ---
        for (int v = 21; v <= 24; v++) begin
            ifc.sample_valid = 1; ifc.sample_data = DW'(v); @(negedge clk);
        end
        ifc.sample_valid = 0;
        repeat (2) @(negedge clk);
        chk("pp.count_before", longint'(ifc.fifo_count), 4);
        ifc.sample_valid = 1; ifc.sample_data = DW'(25); @(negedge clk);
        ifc.sample_valid = 0; ifc.out_ready = 1; @(negedge clk);
        ifc.out_ready = 0;
        chk("pp.count", longint'(ifc.fifo_count), 4);
        chk("pp.overflow", longint'(ifc.overflow), 0);
        chk("pp.head", longint'(ifc.out_data), 22);
        drain_c(10);
        chk("pp_drain.n_out", got_q.size(), 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("pp_drain.out%0d", j), (j < got_q.size()) ? got_q[j] : -1, 22 + j);

        // --- randomized traffic on all three, checked by the model ---
        for (int c = 0; c < 3000; c++) begin
            logic v;
            logic r;
            logic cl;
            logic [DW-1:0] d;
            v = ($urandom % 4) != 0;
            case ($urandom % 5)
                0:       d = 24'h7FFFFF;
                1:       d = 24'h800000;
                2:       d = DW'($urandom % 16);
                default: d = DW'($urandom);
            endcase
            if (((c / 200) % 2) == 1) r = ($urandom % 8) == 0;
            else                      r = ($urandom % 4) != 0;
            cl  = ($urandom % 150) == 0;
            rst = ($urandom % 700) == 0;
            ifa.sample_valid = v; ifa.sample_data = d; ifa.clear = cl; ifa.out_ready = r;
            ifb.sample_valid = v; ifb.sample_data = d; ifb.clear = cl; ifb.out_ready = r;
            ifc.sample_valid = v; ifc.sample_data = d; ifc.clear = cl; ifc.out_ready = r;
            @(negedge clk);
        end
        rst = 0;
        set_idle();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_sample_avg.md
ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, giving the sample width in two's-complement bits.
REQ-002 The block SHALL have parameter LOG2_AVG, default 2, where each output is the average of 2^LOG2_AVG samples; legal range is 0..8.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, giving the number of output FIFO entries; it must be a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port sample_valid, input, 1 bit: one-cycle strobe marking a new ADC reading on sample_data.
REQ-007 The block SHALL have port sample_data, input, DATA_WIDTH bits: signed ADC reading, sampled only when sample_valid is 1.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous flush of the accumulator, FIFO and overflow flag.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data when out_valid and out_ready are both 1.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the FIFO is non-empty and out_data is valid.
REQ-011 The block SHALL have port out_data, output, DATA_WIDTH bits: signed averaged sample at the FIFO head.
REQ-012 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag set when an average is dropped because the FIFO is full.

Function
REQ-014 The accumulator SHALL be a signed register DATA_WIDTH+LOG2_AVG bits wide; each sample SHALL be sign-extended before addition, so it can never wrap.
REQ-015 The sample counter SHALL be LOG2_AVG bits wide and SHALL increment on each accepted sample_valid.
REQ-016 The accumulator state machine SHALL have two states: ACCUM and EMIT.
REQ-017 In ACCUM, a sample_valid with count below 2^LOG2_AVG-1 SHALL add the sample to the accumulator and increment the count.
REQ-018 In ACCUM, a sample_valid with count equal to 2^LOG2_AVG-1 SHALL latch (acc+sample) >>> LOG2_AVG, an arithmetic shift that floors toward minus infinity, into a result register; it SHALL then zero acc and count and go to EMIT.
REQ-019 EMIT SHALL last exactly one cycle, push the result into the FIFO, and return to ACCUM.
REQ-020 A sample_valid arriving during EMIT SHALL be accepted as the first sample of the next group, so back-to-back strobes lose no samples.
REQ-021 With LOG2_AVG=0, every sample SHALL pass through unchanged via EMIT.
REQ-022 Latency from the final sample's strobe to out_valid rising, with the FIFO initially empty, SHALL be 2 cycles.
REQ-023 The FIFO SHALL be first-word-fall-through: out_data SHALL equal the head entry whenever out_valid=1, and SHALL be held stable until popped.
REQ-024 A pop SHALL occur when out_valid and out_ready are both 1; out_ready while out_valid=0 SHALL have no effect.
REQ-025 The read and write pointers SHALL be $clog2(FIFO_DEPTH) bits and SHALL wrap modulo FIFO_DEPTH.
REQ-026 A push and a pop in the same cycle SHALL both take effect, leaving fifo_count unchanged; this SHALL hold even when the FIFO is full.
REQ-027 A push to a full FIFO without a simultaneous pop SHALL be dropped, SHALL set overflow, and SHALL leave the FIFO contents and count unchanged.
REQ-028 overflow SHALL remain set until clear or rst.
REQ-029 On clear=1, the block SHALL zero acc, count and both pointers, empty the FIFO, drop any pending EMIT, clear overflow, and return to ACCUM. clear SHALL take priority over sample_valid, any push and any pop in the same cycle.
REQ-030 The FIFO storage array SHALL need no reset; only pointers, count and flags are reset.

Reset
REQ-031 While rst=1, out_valid, overflow and fifo_count SHALL be 0, out_data SHALL be 0, acc and count SHALL be 0, and the state SHALL be ACCUM, all asynchronously.
REQ-032 Reset asserted mid-group or mid-EMIT SHALL discard the partial sum and the pending result.
REQ-033 Sample acceptance SHALL begin on the first rising edge after rst deasserts.

Verification
REQ-034 Averaging (LOG2_AVG=2): strobe samples 10, 20, 30, 41 -> out_data=25 and out_valid=1 two cycles after the 4th strobe, fifo_count=1.
REQ-035 Signed floor (LOG2_AVG=2): strobe samples -1, -1, -1, -2 -> out_data=-2, i.e. 0xFFFFFE at 24 bits; strobe samples 0x7FFFFF x4 -> out_data=0x7FFFFF with no wrap.
REQ-036 Back-to-back (LOG2_AVG=1): 8 consecutive-cycle strobes of values 1..8 with out_ready=1 -> outputs 1, 3, 5, 7 in order, with no sample lost across EMIT.
REQ-037 Full/overflow (FIFO_DEPTH=4, LOG2_AVG=0, out_ready=0): 5 strobes -> fifo_count=4 and overflow=1, with the 5th value absent; then out_ready=1 -> the first 4 values drain in order and overflow stays 1.
REQ-038 Simultaneous push and pop at full -> count stays 4 and overflow stays 0.
REQ-039 clear mid-group plus sample_valid in the same cycle, then reset mid-EMIT -> in both cases acc=0, count=0, the FIFO is empty, out_valid=0, and the next 4 samples form a fresh group.
